// File: rtl/cdr_pkg.sv
// Shared CDR definitions: bit_count encodings, default phase count, wrapped phase difference.
// Latency: n/a (package). Backpressure: n/a.
// Used by the oversampling sampler and the phase tracker.
package cdr_pkg;

    localparam int CDR_PHASES = 5;

    typedef enum logic [1:0] {
        BC_NONE = 2'd0,
        BC_ONE  = 2'd1,
        BC_TWO  = 2'd2
    } bit_count_e;

    // Signed distance from sel to ideal on a ring of phases, in (-phases/2 .. phases/2].
    function automatic int phase_diff(input int ideal, input int sel, input int phases);
        int d;
        d = (ideal - sel + phases) % phases;
        if (d > phases / 2) begin
            d = d - phases;
        end
        return d;
    endfunction

endpackage

// File: rtl/phase_vote_filter.sv
// Vote filter: integrates early/late votes, steps the sampling pointer, flags pointer wraps.
// Latency: pointer, step pulses and wrap flags update on the accepted word that crosses the threshold.
// Backpressure: none; accept_i low holds every register and drops the step pulses.
module phase_vote_filter
    import cdr_pkg::*;
#(
    parameter int PHASES  = CDR_PHASES,
    parameter int VOTE_TH = 4,
    parameter int VOTE_W  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      accept_i,
    input  logic                      vote_late_i,
    input  logic                      vote_early_i,
    output logic [$clog2(PHASES)-1:0] phase_sel_o,
    output logic                      step_early_o,
    output logic                      step_late_o,
    output logic                      skip_pending_o,
    output logic                      extra_pending_o
);
    localparam int PW      = $clog2(PHASES);
    localparam int ACC_MAX = (1 << (VOTE_W - 1)) - 1;
    localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

    logic signed [VOTE_W-1:0] acc_q, acc_d;
    logic [PW-1:0]            sel_q, sel_d;
    logic                     early_q, early_d, late_q, late_d;
    logic                     skip_q, skip_d, extra_q, extra_d;
    int                       sum;

    always_comb begin
        acc_d   = acc_q;
        sel_d   = sel_q;
        early_d = 1'b0;
        late_d  = 1'b0;
        skip_d  = skip_q;
        extra_d = extra_q;
        sum     = 0;
        if (accept_i) begin
            // A pending wrap is consumed alone, so the two flags can never stack up.
            if (skip_q || extra_q) begin
                skip_d  = 1'b0;
                extra_d = 1'b0;
            end else if (vote_late_i || vote_early_i) begin
                sum = int'(acc_q) + (vote_late_i ? 1 : -1);
                if (sum > ACC_MAX) sum = ACC_MAX;
                if (sum < -ACC_MAX) sum = -ACC_MAX;
                if (sum >= VOTE_TH) begin
                    acc_d  = '0;
                    late_d = 1'b1;
                    sel_d  = (sel_q == LAST) ? '0 : sel_q + 1'b1;
                    skip_d = (sel_q == LAST);
                end else if (sum <= -VOTE_TH) begin
                    acc_d   = '0;
                    early_d = 1'b1;
                    sel_d   = (sel_q == '0) ? LAST : sel_q - 1'b1;
                    extra_d = (sel_q == '0);
                end else begin
                    acc_d = VOTE_W'(sum);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            sel_q   <= PW'(PHASES / 2);
            early_q <= 1'b0;
            late_q  <= 1'b0;
            skip_q  <= 1'b0;
            extra_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sel_q   <= sel_d;
            early_q <= early_d;
            late_q  <= late_d;
            skip_q  <= skip_d;
            extra_q <= extra_d;
        end
    end

    assign phase_sel_o     = sel_q;
    assign step_early_o    = early_q;
    assign step_late_o     = late_q;
    assign skip_pending_o  = skip_q;
    assign extra_pending_o = extra_q;

endmodule

// File: rtl/oversample_phase_tracker.sv
// Oversample phase tracker: edge-driven pointer recovers 0, 1 or 2 bits per oversample word.
// Latency: the bit of an accepted word is emitted two accepted words later; outputs registered.
// Backpressure: none; in_valid low freezes all state and reports bit_count 0 the next cycle.
module oversample_phase_tracker
    import cdr_pkg::*;
#(
    parameter int PHASES     = CDR_PHASES,
    parameter int VOTE_TH    = 4,
    parameter int VOTE_W     = 4,
    parameter int LOCK_EDGES = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [PHASES-1:0]         samples_in,
    input  logic                      in_valid,
    output logic [1:0]                bit_out,
    output logic [1:0]                bit_count,
    output logic                      bit_valid,
    output logic [$clog2(PHASES)-1:0] phase_sel,
    output logic                      locked,
    output logic                      step_early,
    output logic                      step_late
);
    localparam int PW = $clog2(PHASES);
    localparam int LW = $clog2(LOCK_EDGES + 1);

    logic [PHASES-1:0] w0_q, w1_q;
    logic              w2_last_q;   // only the last sample of the oldest word is ever read
    logic [1:0]        fill_q;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              locked_q;
    bit_count_e        bc_q, bc_d;
    logic [1:0]        bits_q, bits_d;
    logic              bvalid_q;

    logic [PHASES-1:0] edges;
    int                n_edges;
    int                diff;
    logic [PW-1:0]     edge_pos;
    logic [PW-1:0]     sel;
    logic              valid_edge, glitch, in_window;
    logic              skip_pend, extra_pend;

    always_comb begin
        edges    = '0;
        n_edges  = 0;
        edge_pos = '0;
        edges[0] = w0_q[0] ^ w1_q[PHASES-1];
        for (int i = 1; i < PHASES; i++) begin
            edges[i] = w0_q[i] ^ w0_q[i-1];
        end
        for (int i = 0; i < PHASES; i++) begin
            if (edges[i]) begin
                n_edges  = n_edges + 1;
                edge_pos = PW'(i);
            end
        end
        valid_edge = (n_edges == 1);
        glitch     = (n_edges > 1);
        diff       = phase_diff((int'(edge_pos) + PHASES / 2) % PHASES, int'(sel), PHASES);
        in_window  = (diff >= -1) && (diff <= 1);
    end

    phase_vote_filter #(
        .PHASES  (PHASES),
        .VOTE_TH (VOTE_TH),
        .VOTE_W  (VOTE_W)
    ) u_filter (
        .clock           (clock),
        .reset           (reset),
        .accept_i        (in_valid),
        .vote_late_i     (valid_edge && (diff > 0)),
        .vote_early_i    (valid_edge && (diff < 0)),
        .phase_sel_o     (sel),
        .step_early_o    (step_early),
        .step_late_o     (step_late),
        .skip_pending_o  (skip_pend),
        .extra_pending_o (extra_pend)
    );

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (in_valid) begin
            if (glitch || (valid_edge && !in_window)) begin
                lock_cnt_d = '0;
            end else if (valid_edge && (lock_cnt_q != LW'(LOCK_EDGES))) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bc_d   = BC_NONE;
        bits_d = 2'b00;
        if (in_valid && (fill_q == 2'd2) && !skip_pend) begin
            if (extra_pend) begin
                bc_d   = BC_TWO;
                bits_d = {w1_q[PHASES-1], w2_last_q};
            end else begin
                bc_d   = BC_ONE;
                bits_d = {1'b0, w1_q[sel]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w0_q       <= '0;
            w1_q       <= '0;
            w2_last_q  <= 1'b0;
            fill_q     <= 2'd0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            bc_q       <= BC_NONE;
            bits_q     <= 2'b00;
            bvalid_q   <= 1'b0;
        end else begin
            if (in_valid) begin
                w0_q      <= samples_in;
                w1_q      <= w0_q;
                w2_last_q <= w1_q[PHASES-1];
                if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            end
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (lock_cnt_d == LW'(LOCK_EDGES));
            bc_q       <= bc_d;
            bits_q     <= bits_d;
            bvalid_q   <= (bc_d != BC_NONE);
        end
    end

    assign bit_out   = bits_q;
    assign bit_count = bc_q;
    assign bit_valid = bvalid_q;
    assign phase_sel = sel;
    assign locked    = locked_q;

endmodule

// File: tb/tb_oversample_phase_tracker.sv
// Directed bench for oversample_phase_tracker (PHASES=5): reset, centred edges, early/late tracking
// with both pointer wraps, glitch, idle gaps and asynchronous reset mid-stream.
module tb_oversample_phase_tracker;
    localparam int P = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic [P-1:0] samples_in;
    logic         in_valid;
    logic [1:0]   bit_out;
    logic [1:0]   bit_count;
    logic         bit_valid;
    logic [2:0]   phase_sel;
    logic         locked;
    logic         step_early;
    logic         step_late;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] WA = 5'b11000;  // edge at 3, ends high
    localparam logic [4:0] WB = 5'b00111;  // edge at 3, ends low
    localparam logic [4:0] WC = 5'b11100;  // edge at 2, ends high
    localparam logic [4:0] WD = 5'b00011;  // edge at 2, ends low

    int exp_ps   [22] = '{2,2,2,2,1,1,1,1,0,0,0,0,4,4,4,4,4,4,0,0,0,0};
    int exp_cnt  [22] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,2,1,1,1,1,1,0,1,1};
    int exp_bits [22] = '{0,0,0,1,0,1,0,1,0,1,0,1,0,1,1,0,1,0,1,0,0,1};
    int exp_se   [22] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,0,0,0,0,0,0};
    int exp_sl   [22] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0};
    int exp_lock [22] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,1,1};

    always #5 clock = ~clock;

    oversample_phase_tracker #(
        .PHASES     (P),
        .VOTE_TH    (4),
        .VOTE_W     (4),
        .LOCK_EDGES (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .samples_in (samples_in),
        .in_valid   (in_valid),
        .bit_out    (bit_out),
        .bit_count  (bit_count),
        .bit_valid  (bit_valid),
        .phase_sel  (phase_sel),
        .locked     (locked),
        .step_early (step_early),
        .step_late  (step_late)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] w);
        samples_in = w;
        in_valid   = 1'b1;
        @(posedge clock);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [4:0] drift_word(input int k);
        if (k < 8)       return k[0] ? WB : WA;
        else if (k < 14) return k[0] ? WD : WC;
        else             return k[0] ? WB : WA;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        samples_in = '0;

        // Reset state, then idle after release.
        @(posedge clock);
        #1;
        check_eq("rst phase_sel", phase_sel, 2);
        check_eq("rst bit_count", bit_count, 0);
        check_eq("rst bit_valid", bit_valid, 0);
        check_eq("rst locked", locked, 0);
        check_eq("rst steps", {step_early, step_late}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check_eq($sformatf("idle%0d bit_count", i), bit_count, 0);
            check_eq($sformatf("idle%0d phase_sel", i), phase_sel, 2);
            check_eq($sformatf("idle%0d locked", i), locked, 0);
        end

        // Centred edges at e=0: no steps, bits alternate 1,0, lock after the 8th edge.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send(k[0] ? 5'b00000 : 5'b11111);
            check_eq($sformatf("ctr k%0d cnt", k), bit_count, (k < 2) ? 0 : 1);
            if (k >= 2) check_eq($sformatf("ctr k%0d bit", k), bit_out, k[0] ? 0 : 1);
            check_eq($sformatf("ctr k%0d ps", k), phase_sel, 2);
            check_eq($sformatf("ctr k%0d steps", k), {step_early, step_late}, 0);
            check_eq($sformatf("ctr k%0d lock", k), locked, (k >= 8) ? 1 : 0);
        end

        // Glitch word: lock drops when it is examined, pointer untouched.
        send(5'b10101);
        check_eq("glitch pre lock", locked, 1);
        check_eq("glitch pre bit", bit_out, 1);
        send(5'b00000);
        check_eq("glitch lock", locked, 0);
        check_eq("glitch ps", phase_sel, 2);
        check_eq("glitch steps", {step_early, step_late}, 0);
        check_eq("glitch bit", bit_out, 0);

        // Idle gap: no output, history kept.
        for (int i = 0; i < 3; i++) begin
            idle();
            check_eq($sformatf("gap%0d cnt", i), bit_count, 0);
            check_eq($sformatf("gap%0d valid", i), bit_valid, 0);
            check_eq($sformatf("gap%0d ps", i), phase_sel, 2);
        end
        send(5'b11111);
        check_eq("gap resume cnt", bit_count, 1);
        check_eq("gap resume bit", bit_out, 1);

        // Early tracking, fast-drift wrap 0->4 (extra bit), slow-drift wrap 4->0 (skip).
        do_reset();
        for (int k = 0; k < 22; k++) begin
            send(drift_word(k));
            check_eq($sformatf("drift k%0d ps", k), phase_sel, exp_ps[k]);
            check_eq($sformatf("drift k%0d cnt", k), bit_count, exp_cnt[k]);
            check_eq($sformatf("drift k%0d valid", k), bit_valid, (exp_cnt[k] != 0) ? 1 : 0);
            check_eq($sformatf("drift k%0d bits", k), bit_out, exp_bits[k]);
            check_eq($sformatf("drift k%0d early", k), step_early, exp_se[k]);
            check_eq($sformatf("drift k%0d late", k), step_late, exp_sl[k]);
            check_eq($sformatf("drift k%0d lock", k), locked, exp_lock[k]);
        end

        // Asynchronous reset right after the 0->4 wrap; the pending extra bit is lost.
        do_reset();
        for (int k = 0; k < 13; k++) send(drift_word(k));
        check_eq("mid pre ps", phase_sel, 4);
        check_eq("mid pre early", step_early, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid rst ps", phase_sel, 2);
        check_eq("mid rst early", step_early, 0);
        check_eq("mid rst lock", locked, 0);
        check_eq("mid rst cnt", bit_count, 0);
        #1;
        reset = 1'b0;
        send(5'b11111);
        check_eq("mid fill0 cnt", bit_count, 0);
        send(5'b00000);
        check_eq("mid fill1 cnt", bit_count, 0);
        send(5'b11111);
        check_eq("mid post cnt", bit_count, 1);
        check_eq("mid post bit", bit_out, 1);
        check_eq("mid post ps", phase_sel, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
